// File: rtl/tank_pkg.sv
// Shared types and screen geometry for the tank movement logic.
package tank_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TURN    = 2'd1,
        MOVE    = 2'd2,
        BACKOFF = 2'd3
    } state_t;

    typedef struct packed {
        logic vld;
        dir_t dir;
    } key_t;

    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
    localparam int OBJECT_SIZE = 25;

    localparam logic [10:0] MAX_X = 11'(SCREEN_W - OBJECT_SIZE);
    localparam logic [10:0] MAX_Y = 11'(SCREEN_H - OBJECT_SIZE);

    // Up beats right beats down beats left.
    function automatic key_t select_key(input logic up, input logic right,
                                        input logic down, input logic left);
        key_t k;
        k.vld = up | right | down | left;
        if (up)
            k.dir = UP;
        else if (right)
            k.dir = RIGHT;
        else if (down)
            k.dir = DOWN;
        else
            k.dir = LEFT;
        return k;
    endfunction

endpackage

// File: rtl/tank_fire_timer.sv
// Fire key edge detect, one pending shot, and per-frame cooldown.
// fireReq is a one-clk pulse the clk after the granting startOfFrame.
module tank_fire_timer
    import tank_pkg::*;
#(
    parameter int FIRE_COOLDOWN = 30
) (
    input  logic clk,
    input  logic resetN,
    input  logic enable,
    input  logic startOfFrame,
    input  logic keyFire,
    output logic fireReq
);

    localparam int CD_W = (FIRE_COOLDOWN < 1) ? 1 : $clog2(FIRE_COOLDOWN + 1);

    logic            key_q;
    logic            pending;
    logic [CD_W-1:0] cooldown;
    logic            fire_edge;
    logic            cool_zero;
    logic            pend_now;

    assign fire_edge = keyFire & ~key_q;
    assign cool_zero = (cooldown == '0);
    // A press landing on the frame pulse itself still counts for that frame.
    assign pend_now  = pending | (fire_edge & cool_zero);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            key_q    <= 1'b0;
            pending  <= 1'b0;
            cooldown <= '0;
            fireReq  <= 1'b0;
        end else begin
            fireReq <= 1'b0;
            if (enable) begin
                key_q <= keyFire;
                if (startOfFrame) begin
                    if (pend_now && cool_zero) begin
                        fireReq  <= 1'b1;
                        pending  <= 1'b0;
                        cooldown <= CD_W'(FIRE_COOLDOWN);
                    end else begin
                        pending <= pend_now;
                        if (!cool_zero)
                            cooldown <= cooldown - CD_W'(1);
                    end
                end else if (fire_edge && cool_zero) begin
                    pending <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/tank_move_controller.sv
// Tank FSM and position: turns, steps every STEP_FRAMES frames, clamps to screen,
// and backs off to the previous position on collision. State changes on startOfFrame only.
module tank_move_controller
    import tank_pkg::*;
#(
    parameter logic [10:0] INIT_X        = 11'd100,
    parameter logic [10:0] INIT_Y        = 11'd400,
    parameter logic [1:0]  INIT_DIR      = 2'b00,
    parameter int          STEP_FRAMES   = 2,
    parameter int          FIRE_COOLDOWN = 30
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        enable,
    input  logic        keyUp,
    input  logic        keyRight,
    input  logic        keyDown,
    input  logic        keyLeft,
    input  logic        keyFire,
    input  logic        collision,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic [1:0]  tankDir,
    output logic        fireReq,
    output logic        moving
);

    localparam int CNT_W = (STEP_FRAMES < 2) ? 1 : $clog2(STEP_FRAMES);

    state_t          state;
    dir_t            dir;
    logic [10:0]     pos_x;
    logic [10:0]     pos_y;
    logic [10:0]     prev_x;
    logic [10:0]     prev_y;
    logic [10:0]     step_x;
    logic [10:0]     step_y;
    logic [CNT_W-1:0] frame_cnt;
    logic            coll_flag;
    logic            at_step;
    key_t            key;

    assign key      = select_key(keyUp, keyRight, keyDown, keyLeft);
    assign at_step  = (frame_cnt == CNT_W'(STEP_FRAMES - 1));
    assign topLeftX = pos_x;
    assign topLeftY = pos_y;
    assign tankDir  = dir;

    // One-pixel step in the current direction, saturating at the screen edges.
    always_comb begin
        step_x = pos_x;
        step_y = pos_y;
        case (dir)
            UP:      step_y = (pos_y == 11'd0) ? pos_y : pos_y - 11'd1;
            RIGHT:   step_x = (pos_x >= MAX_X) ? pos_x : pos_x + 11'd1;
            DOWN:    step_y = (pos_y >= MAX_Y) ? pos_y : pos_y + 11'd1;
            default: step_x = (pos_x == 11'd0) ? pos_x : pos_x - 11'd1;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            dir       <= dir_t'(INIT_DIR);
            pos_x     <= INIT_X;
            pos_y     <= INIT_Y;
            prev_x    <= INIT_X;
            prev_y    <= INIT_Y;
            frame_cnt <= '0;
            coll_flag <= 1'b0;
            moving    <= 1'b0;
        end else if (enable) begin
            if (startOfFrame) begin
                coll_flag <= 1'b0;
                // A collision on the pulse cycle belongs to the frame that is ending.
                if (state != BACKOFF && (coll_flag || collision)) begin
                    pos_x     <= prev_x;
                    pos_y     <= prev_y;
                    frame_cnt <= '0;
                    state     <= BACKOFF;
                    moving    <= 1'b0;
                end else begin
                    case (state)
                        IDLE, TURN: begin
                            if (!key.vld) begin
                                state  <= IDLE;
                                moving <= 1'b0;
                            end else if (key.dir != dir) begin
                                dir    <= key.dir;
                                state  <= TURN;
                                moving <= 1'b0;
                            end else begin
                                state  <= MOVE;
                                moving <= 1'b1;
                            end
                        end
                        MOVE: begin
                            if (!key.vld) begin
                                state     <= IDLE;
                                frame_cnt <= '0;
                                moving    <= 1'b0;
                            end else if (key.dir != dir) begin
                                dir       <= key.dir;
                                state     <= TURN;
                                frame_cnt <= '0;
                                moving    <= 1'b0;
                            end else if (at_step) begin
                                prev_x    <= pos_x;
                                prev_y    <= pos_y;
                                pos_x     <= step_x;
                                pos_y     <= step_y;
                                frame_cnt <= '0;
                            end else begin
                                frame_cnt <= frame_cnt + CNT_W'(1);
                            end
                        end
                        default: begin
                            state  <= IDLE;
                            moving <= 1'b0;
                        end
                    endcase
                end
            end else if (collision) begin
                coll_flag <= 1'b1;
            end
        end
    end

    tank_fire_timer #(
        .FIRE_COOLDOWN(FIRE_COOLDOWN)
    ) u_fire (
        .clk         (clk),
        .resetN      (resetN),
        .enable      (enable),
        .startOfFrame(startOfFrame),
        .keyFire     (keyFire),
        .fireReq     (fireReq)
    );

endmodule

// File: tb/tb_tank_move_controller.sv
// Directed bench: default tank plus a second tank starting next to the right wall.
module tb_tank_move_controller;
    import tank_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetN = 1'b0;
    logic startOfFrame = 1'b0;
    logic enable = 1'b1;
    logic keyUp = 1'b0, keyRight = 1'b0, keyDown = 1'b0, keyLeft = 1'b0;
    logic keyFire = 1'b0, collision = 1'b0;

    logic [10:0] x, y, e_x, e_y;
    logic [1:0]  dir, e_dir;
    logic        fire_req, moving, e_fire, e_moving;

    int checks = 0;
    int failures = 0;
    int fire_cnt = 0;

    tank_move_controller dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable),
        .keyUp(keyUp), .keyRight(keyRight), .keyDown(keyDown), .keyLeft(keyLeft),
        .keyFire(keyFire), .collision(collision),
        .topLeftX(x), .topLeftY(y), .tankDir(dir), .fireReq(fire_req), .moving(moving)
    );

    tank_move_controller #(.INIT_X(11'd614), .INIT_DIR(2'b01)) dut_edge (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable),
        .keyUp(keyUp), .keyRight(keyRight), .keyDown(keyDown), .keyLeft(keyLeft),
        .keyFire(keyFire), .collision(collision),
        .topLeftX(e_x), .topLeftY(e_y), .tankDir(e_dir), .fireReq(e_fire), .moving(e_moving)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        if (fire_req === 1'b1) fire_cnt++;
    endtask

    task automatic frame();
        repeat (3) tick();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic frame_coll();
        tick();
        collision = 1'b1;
        tick();
        collision = 1'b0;
        tick();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic do_reset();
        {keyUp, keyRight, keyDown, keyLeft, keyFire, collision, startOfFrame} = '0;
        enable = 1'b1;
        resetN = 1'b0;
        tick();
        tick();
        resetN = 1'b1;
        tick();
        fire_cnt = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (x !== 11'd100 || y !== 11'd400) begin
            failures++;
            $display("FAIL reset_pos got x=%0d y=%0d want x=100 y=400", x, y);
        end
        checks++;
        if (dir !== 2'b00 || moving !== 1'b0 || fire_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got dir=%0d moving=%0b fire=%0b want 0 0 0", dir, moving, fire_req);
        end
        checks++;
        if (dut.state !== IDLE) begin
            failures++;
            $display("FAIL reset_state got %0d want %0d", dut.state, IDLE);
        end
        checks++;
        if (e_x !== 11'd614 || e_dir !== 2'b01) begin
            failures++;
            $display("FAIL reset_params got x=%0d dir=%0d want x=614 dir=1", e_x, e_dir);
        end
    endtask

    task automatic test_move_right();
        do_reset();
        keyRight = 1'b1;
        frame();
        checks++;
        if (dut.state !== TURN || dir !== 2'b01 || x !== 11'd100 || moving !== 1'b0) begin
            failures++;
            $display("FAIL turn_f1 got st=%0d dir=%0d x=%0d mv=%0b want st=1 dir=1 x=100 mv=0",
                     dut.state, dir, x, moving);
        end
        frame();
        checks++;
        if (dut.state !== MOVE || moving !== 1'b1 || x !== 11'd100) begin
            failures++;
            $display("FAIL move_f2 got st=%0d mv=%0b x=%0d want st=2 mv=1 x=100", dut.state, moving, x);
        end
        frame();
        frame();
        checks++;
        if (x !== 11'd101) begin
            failures++;
            $display("FAIL step_f4 got x=%0d want 101", x);
        end
        frame();
        frame();
        checks++;
        if (x !== 11'd102 || y !== 11'd400) begin
            failures++;
            $display("FAIL step_f6 got x=%0d y=%0d want x=102 y=400", x, y);
        end
        // Asynchronous reset in the middle of a move.
        resetN = 1'b0;
        #2;
        checks++;
        if (x !== 11'd100 || y !== 11'd400 || dir !== 2'b00 || moving !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got x=%0d y=%0d dir=%0d mv=%0b want 100 400 0 0", x, y, dir, moving);
        end
        resetN = 1'b1;
        tick();
        frame();
        checks++;
        if (dut.state !== TURN || dir !== 2'b01 || x !== 11'd100) begin
            failures++;
            $display("FAIL after_reset got st=%0d dir=%0d x=%0d want st=1 dir=1 x=100", dut.state, dir, x);
        end
        keyRight = 1'b0;
    endtask

    task automatic test_wall_clamp();
        do_reset();
        keyRight = 1'b1;
        repeat (3) frame();
        checks++;
        if (e_x !== 11'd615 || e_moving !== 1'b1) begin
            failures++;
            $display("FAIL wall_reach got x=%0d mv=%0b want 615 1", e_x, e_moving);
        end
        for (int f = 0; f < 4; f++) begin
            frame();
            checks++;
            if (e_x !== 11'd615 || e_moving !== 1'b1 || e_y !== 11'd400) begin
                failures++;
                $display("FAIL wall_hold[%0d] got x=%0d y=%0d mv=%0b want 615 400 1", f, e_x, e_y, e_moving);
            end
        end
        keyRight = 1'b0;
    endtask

    task automatic test_collision_backoff();
        do_reset();
        keyUp = 1'b1;
        repeat (3) frame();
        checks++;
        if (y !== 11'd399 || moving !== 1'b1) begin
            failures++;
            $display("FAIL up_step got y=%0d mv=%0b want 399 1", y, moving);
        end
        frame_coll();
        checks++;
        if (y !== 11'd400 || dut.state !== BACKOFF || moving !== 1'b0) begin
            failures++;
            $display("FAIL backoff got y=%0d st=%0d mv=%0b want 400 3 0", y, dut.state, moving);
        end
        frame();
        checks++;
        if (dut.state !== IDLE || y !== 11'd400) begin
            failures++;
            $display("FAIL backoff_exit got st=%0d y=%0d want 0 400", dut.state, y);
        end
        frame();
        checks++;
        if (dut.state !== MOVE) begin
            failures++;
            $display("FAIL remove got st=%0d want 2", dut.state);
        end
        // Collision on the pulse cycle itself.
        repeat (3) tick();
        startOfFrame = 1'b1;
        collision = 1'b1;
        tick();
        startOfFrame = 1'b0;
        collision = 1'b0;
        checks++;
        if (dut.state !== BACKOFF || y !== 11'd400) begin
            failures++;
            $display("FAIL coll_on_sof got st=%0d y=%0d want 3 400", dut.state, y);
        end
        // Collision during BACKOFF is ignored.
        frame_coll();
        checks++;
        if (dut.state !== IDLE) begin
            failures++;
            $display("FAIL backoff_ignores got st=%0d want 0", dut.state);
        end
        keyUp = 1'b0;
    endtask

    task automatic test_fire();
        do_reset();
        keyFire = 1'b1;
        tick();
        keyFire = 1'b0;
        frame();
        checks++;
        if (fire_req !== 1'b1) begin
            failures++;
            $display("FAIL fire_f1 got %0b want 1", fire_req);
        end
        tick();
        checks++;
        if (fire_req !== 1'b0) begin
            failures++;
            $display("FAIL fire_pulse_width got %0b want 0", fire_req);
        end
        for (int f = 2; f <= 31; f++) begin
            if (f == 10) begin
                keyFire = 1'b1;
                tick();
                keyFire = 1'b0;
            end
            frame();
        end
        checks++;
        if (fire_cnt !== 1) begin
            failures++;
            $display("FAIL fire_cooldown got pulses=%0d want 1", fire_cnt);
        end
        keyFire = 1'b1;
        tick();
        keyFire = 1'b0;
        frame();
        checks++;
        if (fire_req !== 1'b1 || fire_cnt !== 2) begin
            failures++;
            $display("FAIL fire_f32 got fire=%0b pulses=%0d want 1 2", fire_req, fire_cnt);
        end
    endtask

    task automatic test_priority();
        do_reset();
        keyLeft = 1'b1;
        frame();
        keyLeft = 1'b0;
        frame();
        checks++;
        if (dir !== 2'b11 || dut.state !== IDLE) begin
            failures++;
            $display("FAIL face_left got dir=%0d st=%0d want 3 0", dir, dut.state);
        end
        keyUp = 1'b1;
        keyLeft = 1'b1;
        frame();
        checks++;
        if (dir !== 2'b00 || dut.state !== TURN) begin
            failures++;
            $display("FAIL up_wins got dir=%0d st=%0d want 0 1", dir, dut.state);
        end
        keyUp = 1'b0;
        keyLeft = 1'b0;
    endtask

    task automatic test_enable_hold();
        do_reset();
        keyUp = 1'b1;
        frame();
        frame();
        enable = 1'b0;
        for (int f = 0; f < 5; f++) begin
            keyFire = 1'b1;
            tick();
            keyFire = 1'b0;
            frame();
            checks++;
            if (y !== 11'd400 || moving !== 1'b1 || dir !== 2'b00) begin
                failures++;
                $display("FAIL frozen[%0d] got y=%0d mv=%0b dir=%0d want 400 1 0", f, y, moving, dir);
            end
        end
        checks++;
        if (fire_cnt !== 0) begin
            failures++;
            $display("FAIL frozen_fire got pulses=%0d want 0", fire_cnt);
        end
        enable = 1'b1;
        frame();
        checks++;
        if (y !== 11'd399 || fire_cnt !== 0) begin
            failures++;
            $display("FAIL resume_step got y=%0d pulses=%0d want 399 0", y, fire_cnt);
        end
        keyUp = 1'b0;
    endtask

    initial begin
        test_reset();
        test_move_right();
        test_wall_clamp();
        test_collision_backoff();
        test_fire();
        test_priority();
        test_enable_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
